// File: rtl/extend_pkg.sv
// extend_pkg: extension mode encoding and default widths shared by the extension unit.
package extend_pkg;

    typedef enum logic [1:0] {
        EXT_SEXT  = 2'b00,
        EXT_ZEXT  = 2'b01,
        EXT_OEXT  = 2'b10,
        EXT_SHEXT = 2'b11
    } ext_mode_t;

    localparam int EXT_IN_W_DEF  = 21;
    localparam int EXT_OUT_W_DEF = 32;

endpackage

// File: rtl/extend_core.sv
// extend_core: combinational sign/zero/ones extension of an IN_W immediate to OUT_W bits.
// Mode 11 shifts the sign-extended value left by one when EXTEND_SHIFT_EN is defined.
module extend_core
    import extend_pkg::*;
#(
    parameter int IN_W  = EXT_IN_W_DEF,
    parameter int OUT_W = EXT_OUT_W_DEF
) (
    input  logic [IN_W-1:0]  extender,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] result
);

    localparam int FILL_W = OUT_W - IN_W;

    generate
        if (IN_W < 2 || OUT_W <= IN_W) begin : g_bad_widths
            $error("extend_core: need IN_W >= 2 and OUT_W > IN_W");
        end
    endgenerate

    ext_mode_t          mode_e;
    logic [FILL_W-1:0]  fill;
    logic [OUT_W-1:0]   sext;

    always_comb begin
        mode_e = ext_mode_t'(mode);
        fill   = (mode_e == EXT_ZEXT) ? '0 :
                 (mode_e == EXT_OEXT) ? '1 : {FILL_W{extender[IN_W-1]}};
        sext   = {fill, extender};
`ifdef EXTEND_SHIFT_EN
        result = (mode_e == EXT_SHEXT) ? {sext[OUT_W-2:0], 1'b0} : sext;
`else
        result = sext;
`endif
    end

endmodule

// File: rtl/extend_unit_21to32.sv
// extend_unit_21to32: registered immediate extension stage (1-cycle latency, 1/clk throughput).
// Mode 11 behaviour depends on EXTEND_SHIFT_EN (see extend_core).
module extend_unit_21to32
    import extend_pkg::*;
#(
    parameter int IN_W  = EXT_IN_W_DEF,
    parameter int OUT_W = EXT_OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  extender,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic [OUT_W-1:0] extendido,
    output logic             out_valid
);

    logic [OUT_W-1:0] core_result;
    logic [OUT_W-1:0] extendido_d, extendido_q;
    logic             out_valid_d, out_valid_q;

    extend_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
        .extender (extender),
        .mode     (mode),
        .result   (core_result)
    );

    // in_valid gates the mux so garbage on idle cycles never reaches the register
    always_comb begin
        extendido_d = in_valid ? core_result : extendido_q;
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            extendido_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            extendido_q <= extendido_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign extendido = extendido_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_extend_unit_21to32.sv
// tb_extend_unit_21to32: scoreboard bench for a 6->11 instance and a default 21->32 instance.
module tb_extend_unit_21to32;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  ea;
    logic [1:0]  ma;
    logic        va;
    logic [10:0] ya;
    logic        oa;
    logic [20:0] eb;
    logic [1:0]  mb;
    logic        vb;
    logic [31:0] yb;
    logic        ob;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] y;
        logic        v;
    } exp_t;

    exp_t        sb_a[$];
    exp_t        sb_b[$];
    logic [10:0] hold_a = '0;
    logic [31:0] hold_b = '0;

    always #5 clk = ~clk;

    extend_unit_21to32 #(.IN_W(6), .OUT_W(11)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .extender  (ea),
        .mode      (ma),
        .in_valid  (va),
        .extendido (ya),
        .out_valid (oa)
    );

    extend_unit_21to32 dut_b (
        .clk       (clk),
        .rst       (rst),
        .extender  (eb),
        .mode      (mb),
        .in_valid  (vb),
        .extendido (yb),
        .out_valid (ob)
    );

    function automatic logic [10:0] model_a(input logic [5:0] e, input logic [1:0] m);
        logic [10:0] s;
        s = 11'($signed(e));
        if (m == 2'd1) return {5'b00000, e};
        if (m == 2'd2) return {5'b11111, e};
`ifdef EXTEND_SHIFT_EN
        if (m == 2'd3) return s << 1;
`endif
        return s;
    endfunction

    function automatic logic [31:0] model_b(input logic [20:0] e, input logic [1:0] m);
        logic [31:0] s;
        s = 32'($signed(e));
        if (m == 2'd1) return {11'h000, e};
        if (m == 2'd2) return {11'h7FF, e};
`ifdef EXTEND_SHIFT_EN
        if (m == 2'd3) return s << 1;
`endif
        return s;
    endfunction

    task automatic check();
        exp_t xa, xb;
        xa = sb_a.pop_front();
        xb = sb_b.pop_front();
        vectors++;
        assert (ya === xa.y[10:0]) else begin
            miscompares++;
            $error("FAIL %s extendido_a observed %h expected %h", xa.tag, ya, xa.y[10:0]);
        end
        vectors++;
        assert (oa === xa.v) else begin
            miscompares++;
            $error("FAIL %s out_valid_a observed %b expected %b", xa.tag, oa, xa.v);
        end
        vectors++;
        assert (yb === xb.y) else begin
            miscompares++;
            $error("FAIL %s extendido_b observed %h expected %h", xb.tag, yb, xb.y);
        end
        vectors++;
        assert (ob === xb.v) else begin
            miscompares++;
            $error("FAIL %s out_valid_b observed %b expected %b", xb.tag, ob, xb.v);
        end
    endtask

    task automatic drive(input bit r, input bit v_a, input logic [5:0] e_a, input logic [1:0] m_a,
                         input bit v_b, input logic [20:0] e_b, input logic [1:0] m_b,
                         input string tag);
        rst = r;
        va  = v_a;
        ea  = v_a ? e_a : 'x;
        ma  = v_a ? m_a : 'x;
        vb  = v_b;
        eb  = v_b ? e_b : 'x;
        mb  = v_b ? m_b : 'x;
        if (r) begin
            hold_a = '0;
            hold_b = '0;
        end else begin
            if (v_a) hold_a = model_a(e_a, m_a);
            if (v_b) hold_b = model_b(e_b, m_b);
        end
        sb_a.push_back('{tag, {21'd0, hold_a}, v_a && !r});
        sb_b.push_back('{tag, hold_b, v_b && !r});
        @(posedge clk);
        #1;
        check();
    endtask

    initial begin
        drive(1, 0, 6'h00, 2'd0, 0, 21'h0, 2'd0, "reset0");
        drive(1, 0, 6'h00, 2'd0, 0, 21'h0, 2'd0, "reset1");
        drive(0, 0, 6'h00, 2'd0, 0, 21'h0, 2'd0, "idle_after_reset");
        drive(0, 1, 6'b000000, 2'd0, 0, 21'h0, 2'd0, "sext_zero");
        drive(0, 1, 6'b010101, 2'd0, 0, 21'h0, 2'd0, "sext_pos");
        drive(0, 1, 6'b100001, 2'd0, 0, 21'h0, 2'd0, "sext_neg");
        drive(0, 1, 6'b100001, 2'd1, 0, 21'h0, 2'd0, "zext_neg");
        drive(0, 0, 6'h00, 2'd0, 0, 21'h0, 2'd0, "idle_hold_x");
        drive(0, 1, 6'b100001, 2'd2, 0, 21'h0, 2'd0, "oext_neg");
        drive(0, 1, 6'b000001, 2'd2, 0, 21'h0, 2'd0, "oext_pos");
        drive(0, 1, 6'b100001, 2'd3, 0, 21'h0, 2'd0, "mode11");
        drive(0, 1, 6'b000000, 2'd1, 1, 21'h100000, 2'd0, "zext_zero_b_sext_min");
        drive(0, 1, 6'b111111, 2'd0, 1, 21'h1FFFFF, 2'd0, "sext_all_ones");
        drive(0, 1, 6'b010000, 2'd3, 1, 21'h1FFFFF, 2'd1, "mode11_pos_b_zext");
        drive(0, 0, 6'h00, 2'd0, 1, 21'h000000, 2'd2, "b_oext_zero");
        drive(0, 0, 6'h00, 2'd0, 1, 21'h0ABCDE, 2'd3, "b_mode11");
        drive(1, 1, 6'b111111, 2'd2, 1, 21'h1FFFFF, 2'd2, "reset_overrides_valid");
        drive(0, 1, 6'b100000, 2'd0, 1, 21'h000001, 2'd0, "first_after_reset_min");
        for (int i = 0; i < 24; i++) begin
            drive(0, 1'($urandom_range(0, 1)), 6'($urandom), 2'($urandom),
                  1'($urandom_range(0, 1)), 21'($urandom), 2'($urandom), "random");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/extend_unit_21to32.md
Name: extend_unit_21to32

Overview:
- Immediate extension unit for the RISC-V datapath.
- Widens an IN_W-bit immediate field to OUT_W bits, by sign or zero extension, with one registered pipeline stage.
- Default configuration: 21-bit J-type immediate to 32-bit operand.
- Sits between instruction decode and the ALU/PC-target adder.

Parameters:
- IN_W, 21, width of the input immediate field; must be at least 2.
- OUT_W, 32, width of the extended result; must be greater than IN_W. Elaboration fails otherwise.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous active-high reset.
- extender  input  IN_W  raw immediate field.
- mode  input  2  extension select, encoded per extend_pkg.
- in_valid  input  1  extender/mode valid this cycle.
- extendido  output  OUT_W  extended result, registered.
- out_valid  output  1  extendido updated on the last rising edge.

Behaviour:
- Single clock; reset is synchronous and active-high on clk/rst. When rst=1 at a rising edge, extendido <= 0 and out_valid <= 0. rst overrides in_valid in the same cycle.
- Latency is exactly 1 cycle. On a rising edge with in_valid=1 and rst=0:
  - extendido <= f(extender, mode)
  - out_valid <= 1
- On a rising edge with in_valid=0 and rst=0:
  - extendido holds its value.
  - out_valid <= 0.
- No backpressure: a new input is accepted every cycle, so throughput is 1 per clock.
- Mode 00 SEXT: extendido[IN_W-1:0] = extender; upper OUT_W-IN_W bits = extender[IN_W-1].
- Mode 01 ZEXT: upper bits = 0.
- Mode 10 OEXT: upper bits = 1. This is used for mask generation.
- Mode 11 reserved: behaves as SEXT unless EXTEND_SHIFT_EN is defined.
- Pure bit replication; no arithmetic, no overflow is possible.
- Boundary cases:
  - Input MSB alone set: SEXT gives the most negative value.
  - All-ones input: SEXT gives all-ones output.
  - All-zero input: output 0 in SEXT and ZEXT.
- Mode and extender are sampled together; a mode change takes effect with that same sample.
- Reset mid-stream discards any in-flight sample. The first valid input after reset deassertion appears one cycle later.
- X on extender while in_valid=0 must not propagate to extendido.

Optional Feature:
- Macro EXTEND_SHIFT_EN.
- Defined: mode 11 = SHEXT. Result is the SEXT value shifted left by 1, truncated to OUT_W, with LSB 0. This is for halfword-scaled branch/jump offsets.
- Undefined: mode 11 is identical to SEXT, and no shifter logic is synthesized.

Decomposition:
- Package extend_pkg holds:
  - typedef enum logic [1:0] ext_mode_t: EXT_SEXT=2'b00, EXT_ZEXT=2'b01, EXT_OEXT=2'b10, EXT_SHEXT=2'b11.
  - Default width constants EXT_IN_W_DEF=21 and EXT_OUT_W_DEF=32.
- One sub-module, extend_core: purely combinational, parameterised by IN_W/OUT_W, computes f(extender, mode).
- The top level adds the register stage, reset and valid tracking.

Test Plan (IN_W=6, OUT_W=11 instance, plus one default-width case):
- rst=1 for 2 cycles, then released with in_valid=0 -> extendido=11'h000, out_valid=0.
- SEXT, extender=6'b000000 -> next cycle extendido=11'h000, out_valid=1.
- SEXT, extender=6'b010101 -> extendido=11'h015. Then SEXT, extender=6'b100001 -> extendido=11'h7E1.
- extender=6'b100001 with ZEXT -> 11'h021. With OEXT -> 11'h7E1. Then extender=6'b000001 with OEXT -> 11'h7C1.
- Mode 11, extender=6'b100001 -> 11'h7C2 with EXTEND_SHIFT_EN, 11'h7E1 without.
- Default widths, SEXT, extender=21'h100000 -> 32'hFFF00000. Assert rst in the same cycle as in_valid -> output 0, out_valid=0.
